// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal/gshare branch predictor.
// Counter helpers work on a 4-bit container; callers slice down to their CTR_WIDTH.
package bp_pkg;

  typedef enum logic {BP_BIMODAL = 1'b0, BP_GSHARE = 1'b1} bp_mode_e;

  localparam int unsigned CTR_MAX_W  = 4;
  localparam int unsigned PC_ALIGN_W = 2;

  // Weakly not-taken: one below the taken threshold.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int unsigned w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_sat(input logic [CTR_MAX_W-1:0] ctr,
                                                   input logic taken,
                                                   input int unsigned w);
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << w) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + CTR_MAX_W'(1);
    else       return (ctr == '0)  ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

  function automatic int unsigned tag_w(input int unsigned data_w, input int unsigned btb_depth);
    return data_w - $clog2(btb_depth) - PC_ALIGN_W;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/execute side bundle of the branch predictor: lookup, prediction,
// training update and the resolved-branch statistics.
interface branch_predictor_gshare_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GHR_WIDTH  = 6
);
  logic                  lookup_valid;
  logic [DATA_WIDTH-1:0] lookup_pc;
  logic                  pred_valid;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic [GHR_WIDTH-1:0]  pred_ghr;
  logic                  update_valid;
  logic [DATA_WIDTH-1:0] update_pc;
  logic [GHR_WIDTH-1:0]  update_ghr;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] update_target;
  logic                  update_mispredict;
  logic [31:0]           branch_count;
  logic [31:0]           mispredict_count;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_ghr, update_taken, update_target, update_mispredict,
    input  pred_valid, pred_taken, pred_target, pred_ghr,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_ghr, update_taken, update_target, update_mispredict,
    output pred_valid, pred_taken, pred_target, pred_ghr,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/bp_sat_counter_table.sv
// Pattern history table of saturating counters: one combinational read port,
// one training port, and write-first forwarding when both hit the same entry.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter  int DEPTH     = 64,
  parameter  int CTR_WIDTH = 2,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [CTR_WIDTH-1:0] rd_ctr,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 wr_taken
);

  localparam logic [CTR_WIDTH-1:0] INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));

  logic [CTR_WIDTH-1:0] mem [DEPTH];
  logic [CTR_MAX_W-1:0] wr_ext;
  logic [CTR_WIDTH-1:0] wr_ctr;

  always_comb begin
    wr_ext = ctr_sat(CTR_MAX_W'(mem[wr_idx]), wr_taken, CTR_WIDTH);
    wr_ctr = wr_ext[CTR_WIDTH-1:0];
    rd_ctr = (wr_en && (wr_idx == rd_idx)) ? wr_ctr : mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Fetch-stage direction/target predictor: PHT (bimodal or gshare index),
// direct-mapped BTB, non-speculative GHR and saturating resolve statistics.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PHT_DEPTH  = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int GHR_WIDTH  = 6,
  parameter int BTB_DEPTH  = 16,
  parameter int MODE       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_predictor_gshare_if.slave bus
);

  localparam int PHT_IDX_W = $clog2(PHT_DEPTH);
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W     = int'(tag_w(DATA_WIDTH, BTB_DEPTH));
  localparam bit GSHARE    = (MODE == int'(BP_GSHARE));

  logic [GHR_WIDTH-1:0]  ghr;
  logic [31:0]           branch_cnt;
  logic [31:0]           mispredict_cnt;

  logic [PHT_IDX_W-1:0]  pht_rd_idx_p0, pht_wr_idx;
  logic [CTR_WIDTH-1:0]  ctr_p0;
  logic [BTB_IDX_W-1:0]  btb_rd_idx_p0, btb_wr_idx;
  logic [TAG_W-1:0]      rd_tag_p0, wr_tag;
  logic                  btb_write, hit_p0;
  logic [DATA_WIDTH-1:0] hit_target_p0;

  logic                  btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]      btb_tag    [BTB_DEPTH];
  logic [DATA_WIDTH-1:0] btb_target [BTB_DEPTH];

  logic                  vld_p1, taken_p1;
  logic [DATA_WIDTH-1:0] target_p1;
  logic [GHR_WIDTH-1:0]  ghr_p1;

  logic unused_bits;
  assign unused_bits = ^{bus.update_pc[1:0], bus.update_ghr};

  function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [PHT_IDX_W-1:0] pc_idx,
                                                     input logic [GHR_WIDTH-1:0] hist);
    return GSHARE ? (pc_idx ^ PHT_IDX_W'(hist)) : pc_idx;
  endfunction

  // Stage p0: index, PHT read and BTB match, with same-cycle training forwarded.
  always_comb begin
    pht_rd_idx_p0 = pht_index(bus.lookup_pc[PHT_IDX_W+1:2], ghr);
    pht_wr_idx    = pht_index(bus.update_pc[PHT_IDX_W+1:2], bus.update_ghr);
    btb_rd_idx_p0 = bus.lookup_pc[BTB_IDX_W+1:2];
    btb_wr_idx    = bus.update_pc[BTB_IDX_W+1:2];
    rd_tag_p0     = bus.lookup_pc[DATA_WIDTH-1:BTB_IDX_W+2];
    wr_tag        = bus.update_pc[DATA_WIDTH-1:BTB_IDX_W+2];
    btb_write     = bus.update_valid && bus.update_taken;
    hit_p0        = btb_valid[btb_rd_idx_p0] && (btb_tag[btb_rd_idx_p0] == rd_tag_p0);
    hit_target_p0 = btb_target[btb_rd_idx_p0];
    if (btb_write && (btb_wr_idx == btb_rd_idx_p0)) begin
      hit_p0        = (wr_tag == rd_tag_p0);
      hit_target_p0 = bus.update_target;
    end
  end

  bp_sat_counter_table #(
    .DEPTH     (PHT_DEPTH),
    .CTR_WIDTH (CTR_WIDTH)
  ) pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pht_rd_idx_p0),
    .rd_ctr   (ctr_p0),
    .wr_en    (bus.update_valid),
    .wr_idx   (pht_wr_idx),
    .wr_taken (bus.update_taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_valid[i] <= 1'b0;
    end else if (btb_write) begin
      btb_valid[btb_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_write) begin
      btb_tag[btb_wr_idx]    <= wr_tag;
      btb_target[btb_wr_idx] <= bus.update_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr            <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (bus.update_valid) begin
      ghr <= GHR_WIDTH'({ghr, bus.update_taken});
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (bus.update_mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  // Stage p1: registered prediction; data holds when no lookup was presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
      ghr_p1    <= '0;
    end else begin
      vld_p1 <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        taken_p1  <= ctr_p0[CTR_WIDTH-1] & hit_p0;
        target_p1 <= hit_p0 ? hit_target_p0 : bus.lookup_pc + DATA_WIDTH'(4);
        ghr_p1    <= ghr;
      end
    end
  end

  assign bus.pred_valid       = vld_p1;
  assign bus.pred_taken       = taken_p1;
  assign bus.pred_target      = target_p1;
  assign bus.pred_ghr         = ghr_p1;
  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench: a bimodal and a gshare instance share directed stimulus;
// expected predictions are queued at issue and popped by per-instance monitors.
module tb_branch_predictor_gshare;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [5:0]  ghr;
    logic        stats;
    logic        actual;
    logic        window;
  } exp_t;

  logic        clk, rst;
  logic        lk_valid, up_valid, up_taken, up_misp, en_b, en_g;
  logic [31:0] lk_pc, up_pc, up_target;
  logic [5:0]  up_ghr;
  logic [5:0]  gm;
  logic        o;
  int          n_pass, n_total, miss_b, miss_g;
  exp_t        q_b[$];
  exp_t        q_g[$];

  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_WIDTH(6)) bus_b ();
  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_WIDTH(6)) bus_g ();

  assign bus_b.lookup_valid      = lk_valid & en_b;
  assign bus_b.lookup_pc         = lk_pc;
  assign bus_b.update_valid      = up_valid & en_b;
  assign bus_b.update_pc         = up_pc;
  assign bus_b.update_ghr        = up_ghr;
  assign bus_b.update_taken      = up_taken;
  assign bus_b.update_target     = up_target;
  assign bus_b.update_mispredict = up_misp;
  assign bus_g.lookup_valid      = lk_valid & en_g;
  assign bus_g.lookup_pc         = lk_pc;
  assign bus_g.update_valid      = up_valid & en_g;
  assign bus_g.update_pc         = up_pc;
  assign bus_g.update_ghr        = up_ghr;
  assign bus_g.update_taken      = up_taken;
  assign bus_g.update_target     = up_target;
  assign bus_g.update_mispredict = up_misp;

  branch_predictor_gshare #(.MODE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  branch_predictor_gshare #(.MODE(1)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic cmp_pred(input string who, input exp_t e, input logic t,
                          input logic [31:0] tgt, input logic [5:0] g, output int miss);
    miss = 0;
    chk32({who, "_pred_ghr"}, 32'(g), 32'(e.ghr));
    if (e.stats) begin
      if (e.window && (t !== e.actual)) miss = 1;
    end else begin
      chk32({who, "_pred_taken"}, 32'(t), 32'(e.taken));
      chk32({who, "_pred_target"}, tgt, e.target);
    end
  endtask

  exp_t eb, eg;
  int   mb, mg;

  always @(negedge clk) begin
    if (bus_b.pred_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        n_total++;
        $display("FAIL mode0_unexpected_pred: got pred_valid 1, required 0");
      end else begin
        eb = q_b.pop_front();
        cmp_pred("mode0", eb, bus_b.pred_taken, bus_b.pred_target, bus_b.pred_ghr, mb);
        miss_b += mb;
      end
    end
  end

  always @(negedge clk) begin
    if (bus_g.pred_valid === 1'b1) begin
      if (q_g.size() == 0) begin
        n_total++;
        $display("FAIL mode1_unexpected_pred: got pred_valid 1, required 0");
      end else begin
        eg = q_g.pop_front();
        cmp_pred("mode1", eg, bus_g.pred_taken, bus_g.pred_target, bus_g.pred_ghr, mg);
        miss_g += mg;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lk_valid = 1'b0;
    up_valid = 1'b0;
    step();
  endtask

  task automatic push(input exp_t e);
    if (en_b) q_b.push_back(e);
    if (en_g) q_g.push_back(e);
  endtask

  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic [5:0] g);
    push('{taken: t, target: tgt, ghr: g, stats: 1'b0, actual: 1'b0, window: 1'b0});
    lk_valid = 1'b1; lk_pc = pc; up_valid = 1'b0;
    step();
    lk_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] g, input logic t,
                     input logic [31:0] tgt, input logic m);
    lk_valid = 1'b0;
    up_valid = 1'b1; up_pc = pc; up_ghr = g; up_taken = t; up_target = tgt; up_misp = m;
    step();
    up_valid = 1'b0;
  endtask

  task automatic do_reset();
    lk_valid = 1'b0; up_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; miss_b = 0; miss_g = 0;
    lk_valid = 0; lk_pc = 0; up_valid = 0; up_pc = 0; up_ghr = 0;
    up_taken = 0; up_target = 0; up_misp = 0; en_b = 1; en_g = 1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_pred_valid", 32'(bus_b.pred_valid), 0);
    chk32("reset_pred_taken", 32'(bus_b.pred_taken), 0);
    chk32("reset_pred_target", bus_b.pred_target, 0);
    chk32("reset_pred_ghr", 32'(bus_b.pred_ghr), 0);
    chk32("reset_branch_count", bus_b.branch_count, 0);
    chk32("reset_mispredict_count", bus_b.mispredict_count, 0);
    chk32("reset_mode1_pred_valid", 32'(bus_g.pred_valid), 0);
    rst = 1'b1;

    // Cold lookup on both instances.
    look(32'h40, 1'b0, 32'h44, 6'h00);
    idle();

    // Bimodal training up, down, and saturation at zero.
    en_g = 1'b0;
    upd(32'h40, 6'h00, 1'b1, 32'h100, 1'b1);
    upd(32'h40, 6'h01, 1'b1, 32'h100, 1'b0);
    look(32'h40, 1'b1, 32'h100, 6'h03);
    upd(32'h40, 6'h03, 1'b0, 32'h100, 1'b1);
    upd(32'h40, 6'h06, 1'b0, 32'h100, 1'b0);
    upd(32'h40, 6'h0C, 1'b0, 32'h100, 1'b0);
    look(32'h40, 1'b0, 32'h100, 6'h18);
    upd(32'h40, 6'h18, 1'b0, 32'h100, 1'b0);
    upd(32'h40, 6'h30, 1'b0, 32'h100, 1'b0);
    upd(32'h40, 6'h20, 1'b0, 32'h100, 1'b0);
    upd(32'h40, 6'h00, 1'b0, 32'h100, 1'b0);
    look(32'h40, 1'b0, 32'h100, 6'h00);
    upd(32'h40, 6'h00, 1'b1, 32'h100, 1'b0);
    look(32'h40, 1'b0, 32'h100, 6'h01);
    idle();
    chk32("mode0_branch_count", bus_b.branch_count, 10);
    chk32("mode0_mispredict_count", bus_b.mispredict_count, 2);
    chk32("mode1_idle_branch_count", bus_g.branch_count, 0);

    // Alternating pattern: gshare learns it, bimodal oscillates.
    do_reset();
    en_g = 1'b1;
    gm = 6'h00;
    for (int i = 0; i < 32; i++) begin
      o = (i % 2 == 0);
      push('{taken: 1'b0, target: 32'h0, ghr: gm, stats: 1'b1, actual: o, window: (i >= 16)});
      lk_valid = 1'b1; lk_pc = 32'h80;
      step();
      upd(32'h80, gm, o, 32'h200, 1'b0);
      gm = {gm[4:0], o};
    end
    idle();
    n_total++;
    if (miss_g < 2) n_pass++;
    else $display("FAIL mode1_pattern_misses: got %0d, required < 2", miss_g);
    chk32("mode0_pattern_misses", 32'(miss_b), 16);

    // Same-cycle train and lookup on the same entry.
    idle();
    do_reset();
    upd(32'h40, 6'h00, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 6'h01, 1'b0, 32'h100, 1'b0);
    push('{taken: 1'b1, target: 32'h100, ghr: 6'h02, stats: 1'b0, actual: 1'b0, window: 1'b0});
    lk_valid = 1'b1; lk_pc = 32'h40;
    up_valid = 1'b1; up_pc = 32'h40; up_ghr = 6'h02; up_taken = 1'b1; up_target = 32'h100; up_misp = 1'b0;
    step();
    idle();

    // BTB aliasing: same set, different tag.
    do_reset();
    en_g = 1'b0;
    upd(32'h40, 6'h00, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 6'h01, 1'b1, 32'h100, 1'b0);
    upd(32'h80, 6'h03, 1'b1, 32'h300, 1'b0);
    look(32'h40, 1'b0, 32'h44, 6'h07);
    look(32'h80, 1'b1, 32'h300, 6'h07);
    idle();

    // Mispredict counter saturation, then asynchronous reset mid-stream.
    force dut_b.mispredict_cnt = 32'hFFFF_FFFE;
    #1 release dut_b.mispredict_cnt;
    upd(32'h200, 6'h07, 1'b0, 32'h0, 1'b1);
    upd(32'h200, 6'h0E, 1'b0, 32'h0, 1'b1);
    upd(32'h200, 6'h1C, 1'b0, 32'h0, 1'b1);
    chk32("mispredict_saturate", bus_b.mispredict_count, 32'hFFFF_FFFF);
    chk32("branch_count_after_sat", bus_b.branch_count, 6);
    look(32'h80, 1'b1, 32'h300, 6'h38);
    lk_valid = 1'b1; lk_pc = 32'h80;
    up_valid = 1'b1; up_pc = 32'h40; up_ghr = 6'h38; up_taken = 1'b1; up_target = 32'h500; up_misp = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk32("async_reset_pred_valid", 32'(bus_b.pred_valid), 0);
    chk32("async_reset_pred_taken", 32'(bus_b.pred_taken), 0);
    chk32("async_reset_pred_target", bus_b.pred_target, 0);
    chk32("async_reset_pred_ghr", 32'(bus_b.pred_ghr), 0);
    chk32("async_reset_branch_count", bus_b.branch_count, 0);
    chk32("async_reset_mispredict_count", bus_b.mispredict_count, 0);
    lk_valid = 1'b0; up_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk32("post_reset_no_pred", 32'(bus_b.pred_valid), 0);
    look(32'h40, 1'b0, 32'h44, 6'h00);
    idle();
    idle();

    chk32("mode0_queue_drained", 32'(q_b.size()), 0);
    chk32("mode1_queue_drained", 32'(q_g.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
